// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory data bus, with bounded
// ownership lock so a locked master cannot starve the other one.
module bus_arbiter #(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wrdata,
  input  logic        m0_wren,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic [31:0] m0_rddata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wrdata,
  input  logic        m1_wren,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rddata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wrdata,
  output logic        bus_wren,
  input  logic [31:0] bus_rddata,
  output logic [1:0]  bus_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  localparam logic [7:0] CNT_MAX = 8'(MAX_LOCK - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;

  logic        own_req, own_lock, oth_req;
  logic        ack0_c, ack1_c;
  logic [31:0] addr_c, wrdata_c;
  logic        wren_c;

  function automatic state_e arbitrate(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? OWN0 : OWN1;
    if (r0)       return OWN0;
    if (r1)       return OWN1;
    return IDLE;
  endfunction

  always_comb begin
    own_req  = (state_q == OWN0) ? m0_req  : m1_req;
    own_lock = (state_q == OWN0) ? m0_lock : m1_lock;
    oth_req  = (state_q == OWN0) ? m1_req  : m0_req;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    ack0_c     = 1'b0;
    ack1_c     = 1'b0;
    addr_c     = '0;
    wrdata_c   = '0;
    wren_c     = 1'b0;
    case (state_q)
      OWN0, OWN1: begin
        if (own_req) begin
          if (state_q == OWN0) begin
            ack0_c   = 1'b1;
            addr_c   = m0_addr;
            wrdata_c = m0_wrdata;
            wren_c   = m0_wren;
          end else begin
            ack1_c   = 1'b1;
            addr_c   = m1_addr;
            wrdata_c = m1_wrdata;
            wren_c   = m1_wren;
          end
          last_d = (state_q == OWN1);
          // Only transactions taken while the other master waits count toward the lock bound.
          if (oth_req && lock_cnt_q != CNT_MAX)
            lock_cnt_d = lock_cnt_q + 8'd1;
          if (oth_req && !(own_lock && lock_cnt_q < CNT_MAX))
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
        end else begin
          state_d = arbitrate(m0_req, m1_req, last_q);
        end
      end
      default: state_d = arbitrate(m0_req, m1_req, last_q);
    endcase
    if (state_d != state_q)
      lock_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    m0_ack     = ack0_c   & ~rst;
    m1_ack     = ack1_c   & ~rst;
    bus_wren   = wren_c   & ~rst;
    bus_addr   = rst ? '0 : addr_c;
    bus_wrdata = rst ? '0 : wrdata_c;
    m0_rddata  = rst ? '0 : bus_rddata;
    m1_rddata  = rst ? '0 : bus_rddata;
    bus_owner  = rst ? 2'b00 : state_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MAX_LOCK=4): expected cycle results are queued
// as each step is driven and checked against the DUT at the following negedge.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m0_lock, m0_ack;
  logic [31:0] m0_addr, m0_wrdata, m0_rddata;
  logic        m1_req, m1_wren, m1_lock, m1_ack;
  logic [31:0] m1_addr, m1_wrdata, m1_rddata;
  logic [31:0] bus_addr, bus_wrdata, bus_rddata;
  logic        bus_wren;
  logic [1:0]  bus_owner;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_wren(m0_wren),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rddata(m0_rddata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_wren(m1_wren),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rddata(m1_rddata),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wren(bus_wren),
    .bus_rddata(bus_rddata), .bus_owner(bus_owner)
  );

  typedef struct {
    string       tag;
    logic [1:0]  owner;
    logic        a0, a1, wren;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  exp_t q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk1(input string tag, input string fld, input logic obs, input logic ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, ex);
    end
  endtask

  task automatic chk32(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] ex);
    n_assert++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, ex);
    end
  endtask

  // Expected bus contents follow from which master should be acked this cycle.
  task automatic cyc(input string tag, input logic [1:0] owner, input logic a0, input logic a1);
    exp_t e, got;
    e.tag   = tag;
    e.owner = rst ? 2'b00 : owner;
    e.a0    = a0 & ~rst;
    e.a1    = a1 & ~rst;
    e.wren  = e.a0 ? m0_wren   : e.a1 ? m1_wren   : 1'b0;
    e.addr  = e.a0 ? m0_addr   : e.a1 ? m1_addr   : 32'h0;
    e.wdata = e.a0 ? m0_wrdata : e.a1 ? m1_wrdata : 32'h0;
    e.rdata = rst ? 32'h0 : bus_rddata;
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    n_assert++;
    assert (bus_owner === got.owner) else begin
      n_fail++;
      $error("FAIL %s.owner observed=%b expected=%b", got.tag, bus_owner, got.owner);
    end
    chk1(got.tag, "m0_ack", m0_ack, got.a0);
    chk1(got.tag, "m1_ack", m1_ack, got.a1);
    chk1(got.tag, "wren", bus_wren, got.wren);
    chk32(got.tag, "addr", bus_addr, got.addr);
    chk32(got.tag, "wdata", bus_wrdata, got.wdata);
    chk32(got.tag, "m0_rd", m0_rddata, got.rdata);
    chk32(got.tag, "m1_rd", m1_rddata, got.rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b1; m0_wren = 1'b1; m0_lock = 1'b0;
    m0_addr = 32'h1000_0000; m0_wrdata = 32'h1111_1111;
    m1_req = 1'b1; m1_wren = 1'b1; m1_lock = 1'b0;
    m1_addr = 32'h2000_0000; m1_wrdata = 32'h2222_2222;
    bus_rddata = 32'hCAFE_0001;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) cyc("reset", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("rel_idle", 2'b00, 1'b0, 1'b0);

    // Contention without lock: eight alternating acks starting with master 0.
    for (int i = 0; i < 4; i++) begin
      cyc("rr_m0", 2'b01, 1'b1, 1'b0);
      cyc("rr_m1", 2'b10, 1'b0, 1'b1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc("rr_drop", 2'b01, 1'b0, 1'b0);
    cyc("rr_idle", 2'b00, 1'b0, 1'b0);

    // Single master write then read of the same address.
    m1_req = 1'b1; m1_wren = 1'b1;
    m1_addr = 32'h1001_0004; m1_wrdata = 32'hDEAD_BEEF;
    cyc("sm_req", 2'b00, 1'b0, 1'b0);
    cyc("sm_wr", 2'b10, 1'b0, 1'b1);
    m1_wren = 1'b0; bus_rddata = 32'hDEAD_BEEF;
    cyc("sm_rd", 2'b10, 1'b0, 1'b1);
    m1_req = 1'b0;
    cyc("sm_drop", 2'b10, 1'b0, 1'b0);
    cyc("sm_idle", 2'b00, 1'b0, 1'b0);

    // Locked master 0 keeps the bus while alone, then exactly 4 acks under contention.
    m0_req = 1'b1; m0_lock = 1'b1; m0_wren = 1'b0;
    cyc("lk_req", 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("lk_alone", 2'b01, 1'b1, 1'b0);
    m1_req = 1'b1; m1_wren = 1'b1;
    for (int i = 0; i < 4; i++) cyc("lk_bound", 2'b01, 1'b1, 1'b0);
    cyc("lk_switch", 2'b10, 1'b0, 1'b1);

    // Owner drops req in its own cycle while master 1 waits.
    m0_req = 1'b0; m0_lock = 1'b0;
    cyc("pv_noack", 2'b01, 1'b0, 1'b0);
    cyc("pv_m1", 2'b10, 1'b0, 1'b1);

    // Reset pulse while master 1 owns with a write pending.
    rst = 1'b1;
    cyc("rst_mid", 2'b10, 1'b0, 1'b1);
    rst = 1'b0;
    cyc("rst_idle", 2'b00, 1'b0, 1'b0);
    cyc("rst_regrant", 2'b10, 1'b0, 1'b1);
    m1_req = 1'b0;
    cyc("end_drop", 2'b10, 1'b0, 1'b0);
    cyc("end_idle", 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
